// File: rtl/fetch_stage.sv
// Fetch stage: sits between pre-fetch and decode. Holds at most one
// outstanding ICache request in a wait register and remembers whether a
// flushed request still has an orphan response on its way. Returned
// instruction groups go into a circular, in-order instruction queue, and
// decode drains up to two entries per cycle.
module fetch_stage #(
    parameter int QDEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        pfs_to_valid,
    input  logic        pfs_slot0_valid,
    input  logic [31:0] pfs_pc,
    input  logic        pfs_ex,
    input  logic [4:0]  pfs_exccode,
    output logic        fs_allowin,
    input  logic        icache_data_ok,
    input  logic [63:0] icache_rdata,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid0,
    output logic        fs_to_ds_valid1,
    output logic [31:0] fs_to_ds_pc0,
    output logic [31:0] fs_to_ds_pc1,
    output logic [31:0] fs_to_ds_inst0,
    output logic [31:0] fs_to_ds_inst1,
    output logic        fs_to_ds_ex0,
    output logic        fs_to_ds_ex1,
    output logic [4:0]  fs_to_ds_exccode0,
    output logic [4:0]  fs_to_ds_exccode1
);

    localparam int PTR_W = $clog2(QDEPTH);

    // S_WAIT means a request is outstanding (wait_valid); S_CANCEL means a
    // flushed request's response must still be swallowed (cancel).
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CANCEL} state_t;

    state_t             state;
    state_t             state_next;

    logic [31:3]        wait_pc;
    logic               wait_slot0;

    logic [31:0]        q_pc      [QDEPTH];
    logic [31:0]        q_inst    [QDEPTH];
    logic               q_ex      [QDEPTH];
    logic [4:0]         q_exccode [QDEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head_p1;
    logic [PTR_W-1:0]   tail_p1;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     free_entries;

    logic               accept;
    logic               ex_push;
    logic               data_push;
    logic               push_any;
    logic               push_slot0;
    logic [31:3]        push_base;
    logic [31:0]        push_inst0;
    logic [31:0]        push_inst1;
    logic               push_ex;
    logic [4:0]         push_exccode;
    logic [1:0]         push_cnt;
    logic [1:0]         pop_cnt;

    // The group PC is 8-byte aligned; its low bits carry no information.
    logic               unused_pfs_pc_low;
    assign unused_pfs_pc_low = ^pfs_pc[2:0];

    // Request-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next request-tracking state: flush without data leaves an orphan to swallow.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && !pfs_ex) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush && !icache_data_ok)     state_next = S_CANCEL;
                else if (flush || icache_data_ok) state_next = S_IDLE;
            end
            S_CANCEL: begin
                if (icache_data_ok) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and push decisions derived from the tracking state.
    always_comb begin
        free_entries = (PTR_W+1)'(QDEPTH) - count;
        fs_allowin   = !reset && (state == S_IDLE) && (free_entries >= (PTR_W+1)'(2));
        accept       = pfs_to_valid && fs_allowin && !flush;
        ex_push      = accept && pfs_ex;
        data_push    = !reset && (state == S_WAIT) && icache_data_ok && !flush;
        push_any     = ex_push || data_push;
    end

    // Select what gets pushed: an exception group straight from pre-fetch, or ICache data.
    always_comb begin
        push_slot0   = wait_slot0;
        push_base    = wait_pc;
        push_inst0   = icache_rdata[31:0];
        push_inst1   = icache_rdata[63:32];
        push_ex      = 1'b0;
        push_exccode = 5'd0;
        if (ex_push) begin
            push_slot0   = pfs_slot0_valid;
            push_base    = pfs_pc[31:3];
            push_inst0   = 32'd0;
            push_inst1   = 32'd0;
            push_ex      = 1'b1;
            push_exccode = pfs_exccode;
        end
        push_cnt = push_any ? (push_slot0 ? 2'd2 : 2'd1) : 2'd0;
        pop_cnt  = !ds_allowin                 ? 2'd0 :
                   (count >= (PTR_W+1)'(2))    ? 2'd2 : {1'b0, count[0]};
    end

    // Wait register captures an accepted group that went out to the ICache.
    always_ff @(posedge clk) begin
        if (accept && !pfs_ex) begin
            wait_pc    <= pfs_pc[31:3];
            wait_slot0 <= pfs_slot0_valid;
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
        end
    end

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Queue storage: slot0 is written ahead of slot1 so program order is kept.
    always_ff @(posedge clk) begin
        if (push_any) begin
            if (push_slot0) begin
                q_pc[tail]         <= {push_base, 3'b000};
                q_inst[tail]       <= push_inst0;
                q_ex[tail]         <= push_ex;
                q_exccode[tail]    <= push_exccode;
                q_pc[tail_p1]      <= {push_base, 3'b100};
                q_inst[tail_p1]    <= push_inst1;
                q_ex[tail_p1]      <= push_ex;
                q_exccode[tail_p1] <= push_exccode;
            end else begin
                q_pc[tail]         <= {push_base, 3'b100};
                q_inst[tail]       <= push_inst1;
                q_ex[tail]         <= push_ex;
                q_exccode[tail]    <= push_exccode;
            end
        end
    end

    // Present the two oldest entries to decode; nothing is offered during a flush.
    always_comb begin
        fs_to_ds_valid0   = !reset && !flush && (count != '0);
        fs_to_ds_valid1   = !reset && !flush && (count >= (PTR_W+1)'(2));
        fs_to_ds_pc0      = q_pc[head];
        fs_to_ds_pc1      = q_pc[head_p1];
        fs_to_ds_inst0    = q_inst[head];
        fs_to_ds_inst1    = q_inst[head_p1];
        fs_to_ds_ex0      = q_ex[head];
        fs_to_ds_ex1      = q_ex[head_p1];
        fs_to_ds_exccode0 = q_exccode[head];
        fs_to_ds_exccode1 = q_exccode[head_p1];
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based
// behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam int QDEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        pfs_to_valid;
    logic        pfs_slot0_valid;
    logic [31:0] pfs_pc;
    logic        pfs_ex;
    logic [4:0]  pfs_exccode;
    logic        fs_allowin;
    logic        icache_data_ok;
    logic [63:0] icache_rdata;
    logic        ds_allowin;
    logic        fs_to_ds_valid0, fs_to_ds_valid1;
    logic [31:0] fs_to_ds_pc0, fs_to_ds_pc1;
    logic [31:0] fs_to_ds_inst0, fs_to_ds_inst1;
    logic        fs_to_ds_ex0, fs_to_ds_ex1;
    logic [4:0]  fs_to_ds_exccode0, fs_to_ds_exccode1;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.QDEPTH(QDEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .pfs_to_valid      (pfs_to_valid),
        .pfs_slot0_valid   (pfs_slot0_valid),
        .pfs_pc            (pfs_pc),
        .pfs_ex            (pfs_ex),
        .pfs_exccode       (pfs_exccode),
        .fs_allowin        (fs_allowin),
        .icache_data_ok    (icache_data_ok),
        .icache_rdata      (icache_rdata),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid0   (fs_to_ds_valid0),
        .fs_to_ds_valid1   (fs_to_ds_valid1),
        .fs_to_ds_pc0      (fs_to_ds_pc0),
        .fs_to_ds_pc1      (fs_to_ds_pc1),
        .fs_to_ds_inst0    (fs_to_ds_inst0),
        .fs_to_ds_inst1    (fs_to_ds_inst1),
        .fs_to_ds_ex0      (fs_to_ds_ex0),
        .fs_to_ds_ex1      (fs_to_ds_ex1),
        .fs_to_ds_exccode0 (fs_to_ds_exccode0),
        .fs_to_ds_exccode1 (fs_to_ds_exccode1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [4:0]  exccode;
    } entry_t;

    entry_t      mq[$];
    bit          m_wait   = 1'b0;
    bit          m_cancel = 1'b0;
    logic [31:0] m_pc;
    bit          m_slot0;
    bit          m_admit;
    int          m_npop;

    function automatic void modelPush(logic [31:0] pc, bit slot0, logic [63:0] data,
                                      bit ex, logic [4:0] code);
        entry_t e;
        if (slot0) begin
            e.pc = {pc[31:3], 3'b000}; e.inst = data[31:0];
            e.ex = ex; e.exccode = code;
            mq.push_back(e);
        end
        e.pc = {pc[31:3], 3'b100}; e.inst = data[63:32];
        e.ex = ex; e.exccode = code;
        mq.push_back(e);
    endfunction

    // Advance the model on each rising edge from the inputs held during that cycle.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_wait   = 1'b0;
            m_cancel = 1'b0;
        end else begin
            m_admit = pfs_to_valid && !flush && !m_wait && !m_cancel
                      && (QDEPTH - mq.size() >= 2);
            m_npop  = ds_allowin ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
            if (flush) begin
                mq.delete();
                if (m_wait) begin
                    m_cancel = !icache_data_ok;
                    m_wait   = 1'b0;
                end else if (m_cancel && icache_data_ok) begin
                    m_cancel = 1'b0;
                end
            end else begin
                repeat (m_npop) void'(mq.pop_front());
                if (m_cancel && icache_data_ok) begin
                    m_cancel = 1'b0;
                end else if (m_wait && icache_data_ok) begin
                    modelPush(m_pc, m_slot0, icache_rdata, 1'b0, 5'd0);
                    m_wait = 1'b0;
                end
                if (m_admit) begin
                    if (pfs_ex) begin
                        modelPush(pfs_pc, pfs_slot0_valid, 64'd0, 1'b1, pfs_exccode);
                    end else begin
                        m_wait  = 1'b1;
                        m_pc    = pfs_pc;
                        m_slot0 = pfs_slot0_valid;
                    end
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        bit exp_v0, exp_v1, exp_allow;
        exp_allow = !reset && !m_wait && !m_cancel && (QDEPTH - mq.size() >= 2);
        exp_v0    = !reset && !flush && (mq.size() >= 1);
        exp_v1    = !reset && !flush && (mq.size() >= 2);
        checkOutput("model_allowin", {31'd0, fs_allowin}, {31'd0, exp_allow});
        checkOutput("model_valid0", {31'd0, fs_to_ds_valid0}, {31'd0, exp_v0});
        checkOutput("model_valid1", {31'd0, fs_to_ds_valid1}, {31'd0, exp_v1});
        if (exp_v0) begin
            checkOutput("model_pc0", fs_to_ds_pc0, mq[0].pc);
            checkOutput("model_inst0", fs_to_ds_inst0, mq[0].inst);
            checkOutput("model_ex0", {31'd0, fs_to_ds_ex0}, {31'd0, mq[0].ex});
            checkOutput("model_exc0", {27'd0, fs_to_ds_exccode0}, {27'd0, mq[0].exccode});
        end
        if (exp_v1) begin
            checkOutput("model_pc1", fs_to_ds_pc1, mq[1].pc);
            checkOutput("model_inst1", fs_to_ds_inst1, mq[1].inst);
            checkOutput("model_ex1", {31'd0, fs_to_ds_ex1}, {31'd0, mq[1].ex});
            checkOutput("model_exc1", {27'd0, fs_to_ds_exccode1}, {27'd0, mq[1].exccode});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        flush           = 1'b0;
        pfs_to_valid    = 1'b0;
        pfs_slot0_valid = 1'b0;
        pfs_pc          = 32'd0;
        pfs_ex          = 1'b0;
        pfs_exccode     = 5'd0;
        icache_data_ok  = 1'b0;
        icache_rdata    = 64'd0;
        ds_allowin      = 1'b0;
    endtask

    task automatic applyStimulus();
        reset           = ($urandom_range(0, 199) == 0);
        flush           = ($urandom_range(0, 15) == 0);
        pfs_to_valid    = ($urandom_range(0, 1) == 1);
        pfs_slot0_valid = ($urandom_range(0, 1) == 1);
        pfs_pc          = {$urandom(), 3'b000} & 32'hffff_fff8;
        pfs_ex          = ($urandom_range(0, 7) == 0);
        pfs_exccode     = 5'($urandom_range(0, 31));
        icache_data_ok  = (m_wait || m_cancel) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 7) == 0);
        icache_rdata    = {$urandom(), $urandom()};
        ds_allowin      = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;

        // Reset state.
        @(negedge clk);
        checkOutput("reset_allowin", {31'd0, fs_allowin}, 32'd0);
        checkOutput("reset_valid0", {31'd0, fs_to_ds_valid0}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_allowin", {31'd0, fs_allowin}, 32'd1);
        checkOutput("post_reset_valid0", {31'd0, fs_to_ds_valid0}, 32'd0);

        // Aligned fetch.
        pfs_to_valid = 1'b1; pfs_pc = 32'hbfc00000; pfs_slot0_valid = 1'b1;
        tick();
        pfs_to_valid = 1'b0;
        @(negedge clk);
        checkOutput("aligned_wait_allowin", {31'd0, fs_allowin}, 32'd0);
        tick();
        icache_data_ok = 1'b1; icache_rdata = 64'h24020002_24010001;
        tick();
        icache_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("aligned_valid0", {31'd0, fs_to_ds_valid0}, 32'd1);
        checkOutput("aligned_valid1", {31'd0, fs_to_ds_valid1}, 32'd1);
        checkOutput("aligned_pc0", fs_to_ds_pc0, 32'hbfc00000);
        checkOutput("aligned_inst0", fs_to_ds_inst0, 32'h24010001);
        checkOutput("aligned_pc1", fs_to_ds_pc1, 32'hbfc00004);
        checkOutput("aligned_inst1", fs_to_ds_inst1, 32'h24020002);
        ds_allowin = 1'b1;
        tick();
        ds_allowin = 1'b0;

        // Branch target in the odd word: one entry only.
        pfs_to_valid = 1'b1; pfs_pc = 32'h80001008; pfs_slot0_valid = 1'b0;
        tick();
        pfs_to_valid = 1'b0;
        icache_data_ok = 1'b1; icache_rdata = 64'haaaa5555_12345678;
        tick();
        icache_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("odd_valid0", {31'd0, fs_to_ds_valid0}, 32'd1);
        checkOutput("odd_valid1", {31'd0, fs_to_ds_valid1}, 32'd0);
        checkOutput("odd_pc0", fs_to_ds_pc0, 32'h8000100c);
        checkOutput("odd_inst0", fs_to_ds_inst0, 32'haaaa5555);
        ds_allowin = 1'b1;
        tick();
        ds_allowin = 1'b0;

        // Flush while waiting: the late response is swallowed.
        pfs_to_valid = 1'b1; pfs_pc = 32'h80000000; pfs_slot0_valid = 1'b1;
        tick();
        pfs_to_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; icache_data_ok = 1'b1; icache_rdata = 64'hdeadbeef_cafef00d;
        @(negedge clk);
        checkOutput("cancel_allowin", {31'd0, fs_allowin}, 32'd0);
        tick();
        icache_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("cancel_done_allowin", {31'd0, fs_allowin}, 32'd1);
        checkOutput("cancel_done_valid0", {31'd0, fs_to_ds_valid0}, 32'd0);

        // Exception group: pushed directly, no ICache response.
        pfs_to_valid = 1'b1; pfs_ex = 1'b1; pfs_exccode = 5'h04;
        pfs_pc = 32'h80000004; pfs_slot0_valid = 1'b1;
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("exc_valid1", {31'd0, fs_to_ds_valid1}, 32'd1);
        checkOutput("exc_pc0", fs_to_ds_pc0, 32'h80000000);
        checkOutput("exc_pc1", fs_to_ds_pc1, 32'h80000004);
        checkOutput("exc_ex0", {31'd0, fs_to_ds_ex0}, 32'd1);
        checkOutput("exc_code1", {27'd0, fs_to_ds_exccode1}, 32'd4);
        checkOutput("exc_inst0", fs_to_ds_inst0, 32'd0);
        checkOutput("exc_allowin", {31'd0, fs_allowin}, 32'd1);
        ds_allowin = 1'b1;
        tick();
        ds_allowin = 1'b0;

        // Backpressure: fill the queue, then drain in order.
        for (int g = 0; g < 4; g++) begin
            pfs_to_valid = 1'b1; pfs_pc = 32'h80002000 + 32'(8 * g); pfs_slot0_valid = 1'b1;
            tick();
            pfs_to_valid = 1'b0;
            icache_data_ok = 1'b1; icache_rdata = {32'(g) ^ 32'hffffffff, 32'(g)};
            tick();
            icache_data_ok = 1'b0;
        end
        ds_allowin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_pc0", fs_to_ds_pc0, 32'h80002000 + 32'(8 * k));
            checkOutput("bp_pc1", fs_to_ds_pc1, 32'h80002004 + 32'(8 * k));
            checkOutput("bp_allowin", {31'd0, fs_allowin}, (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        ds_allowin = 1'b0;

        // Flush coinciding with data_ok: no push and no pending cancel.
        pfs_to_valid = 1'b1; pfs_pc = 32'h80003000; pfs_slot0_valid = 1'b1;
        tick();
        pfs_to_valid = 1'b0; flush = 1'b1; icache_data_ok = 1'b1;
        tick();
        flush = 1'b0; icache_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("flush_ok_allowin", {31'd0, fs_allowin}, 32'd1);
        checkOutput("flush_ok_valid0", {31'd0, fs_to_ds_valid0}, 32'd0);

        // Reset while waiting: the later response is ignored.
        pfs_to_valid = 1'b1; pfs_pc = 32'h80004000; pfs_slot0_valid = 1'b1;
        tick();
        pfs_to_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; icache_data_ok = 1'b1; icache_rdata = 64'h11112222_33334444;
        tick();
        icache_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("rst_wait_valid0", {31'd0, fs_to_ds_valid0}, 32'd0);
        checkOutput("rst_wait_allowin", {31'd0, fs_allowin}, 32'd1);

        // Randomized traffic checked by the model.
        repeat (4000) begin
            applyStimulus();
            tick();
        end
        clearInputs();
        reset = 1'b0;
        ds_allowin = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Sits directly downstream of the pre-fetch stage and upstream of decode.
- Accepts fetch groups of one or two instructions: the group PC plus a slot0-valid flag.
- Tracks the single outstanding ICache response, discards responses killed by flush, and writes returned instructions into an in-order instruction queue.
- Decode drains the queue up to two instructions per cycle.

Parameters:
- QDEPTH, 8, instruction queue entries; power of two, ≥4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (exception/eret/mispredict redirect)
- pfs_to_valid  in  1  pre-fetch hands over a fetch group this cycle
- pfs_slot0_valid  in  1  slot0 (pc[2]=0 word) is part of the group
- pfs_pc  in  32  group base PC, low 3 bits zero
- pfs_ex  in  1  group carries an address exception; no ICache request was made
- pfs_exccode  in  5  exception code (ADEL)
- fs_allowin  out  1  fetch stage can accept a group
- icache_data_ok  in  1  ICache returns data for the outstanding request
- icache_rdata  in  64  [31:0]=slot0 word, [63:32]=slot1 word
- ds_allowin  in  1  decode accepts up to two instructions
- fs_to_ds_valid0 / fs_to_ds_valid1  out  1 each  queue head / head+1 valid
- fs_to_ds_pc0 / fs_to_ds_pc1  out  32 each  PCs
- fs_to_ds_inst0 / fs_to_ds_inst1  out  32 each  instruction words
- fs_to_ds_ex0 / fs_to_ds_ex1  out  1 each  exception flags
- fs_to_ds_exccode0 / fs_to_ds_exccode1  out  5 each  exception codes

Behaviour:
Reset:
- wait_valid=0, cancel=0, queue empty, fs_allowin=0 during reset.
- All fs_to_ds_valid*=0; data outputs are don't-care while invalid.

Wait register (wait_valid, pc, slot0_valid, ex, exccode):
- fs_allowin = !wait_valid && !cancel && free_entries≥2.
- Accepting a group requires pfs_to_valid && fs_allowin && !flush.
- Accepted with pfs_ex=1: push directly the same cycle; wait register not loaded.
  - Push slot0 if slot0_valid, then slot1 (pc+4).
  - Each pushed entry gets ex=1, the given exccode, inst=0, pc={pfs_pc[31:3],pc[2],2'b00}.
- Accepted with pfs_ex=0: load the wait register.
- icache_data_ok with wait_valid=1, no flush:
  - Push slot0 (rdata[31:0]) if slot0_valid, then slot1 (rdata[63:32]).
  - Clear wait_valid.
  - Latency: push occurs at the data_ok edge; entries are visible at outputs the next cycle.
- icache_data_ok with cancel=1: discard data; clear cancel.
- Flush with wait_valid=1 and no data_ok that cycle: clear wait_valid, set cancel=1.
- Flush in the same cycle as data_ok: discard data; cancel stays 0.
- Flush with cancel already 1: cancel stays 1; at most one orphan response exists.
- icache_data_ok with neither wait_valid nor cancel set: ignored.

Queue:
- Circular, head/tail pointers of log2(QDEPTH) bits, count of log2(QDEPTH)+1 bits.
- Pointers wrap modulo QDEPTH.
- fs_to_ds_valid0 = count≥1 && !flush.
- fs_to_ds_valid1 = count≥2 && !flush.
- Pop = ds_allowin ? min(count,2) : 0, applied at the clock edge.
- Push and pop in the same cycle are both applied:
  - count_next = count + push − pop.
  - Never overflows, because admission required ≥2 free entries.
- Slot order is preserved: slot0 always precedes slot1 of the same group.
- Flush clears the queue: head=tail=count=0 next cycle. No push occurs that cycle.

Reset mid-operation:
- Reset dominates flush and all other inputs.
- Clears wait_valid and cancel, so an in-flight response after reset is ignored.

Test Plan:
- Aligned fetch: group pc=0xbfc00000, slot0_valid=1; data_ok 2 cycles later, rdata=0x24020002_24010001 -> next cycle valid0/1=1, pc0=0xbfc00000 inst0=0x24010001, pc1=0xbfc00004 inst1=0x24020002.
- Branch-target group: pc=0x80001008 with slot0_valid=0 (odd word) -> exactly one entry, pc0=0x8000100c inst=rdata[63:32], count=1.
- Flush while waiting: accept pc=0x80000000, assert flush the next cycle, data_ok one cycle later -> nothing pushed; cancel clears; fs_allowin returns to 1 the cycle after data_ok.
- Backpressure: ds_allowin=0, stream 4 aligned groups, QDEPTH=8 -> count reaches 8, fs_allowin=0 from count≥7. Then ds_allowin=1 -> pops 2 per cycle in PC order, and fs_allowin reasserts once count≤6.
- Exception group: pfs_ex=1, exccode=0x04, pc=0x80000004, slot0_valid=1, no data_ok -> two entries next cycle with ex=1, exccode=4, inst=0.
- Flush coinciding with data_ok, plus reset while waiting -> no push, cancel=0, queue empty; a later data_ok is ignored.
